// File: rtl/nonrestoring_divider_seq.sv
// rtl/nonrestoring_divider_seq.sv - parametrised sequential non-restoring divider with signed mode and exception flags
module nonrestoring_divider_seq #(
    parameter int WIDTH     = 16,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ITER, CORRECT, FINISH} state_t;

    state_t           state, state_nx;
    logic [WIDTH:0]   a_reg, m_reg;
    logic [WIDTH-1:0] q_reg;
    logic [CW-1:0]    cnt;
    logic             sign_q, sign_r;

    logic             accept, sgn, dvd_neg, dvs_neg;
    logic             exc_zero, exc_ovf, iter_last;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic [WIDTH:0]   a_shift, a_step, a_fix;

    always_comb begin
        accept    = start && (state == IDLE);
        sgn       = SIGNED_EN && signed_mode;
        dvd_neg   = sgn && dividend[WIDTH-1];
        dvs_neg   = sgn && divisor[WIDTH-1];
        dvd_mag   = dvd_neg ? -dividend : dividend;
        dvs_mag   = dvs_neg ? -divisor : divisor;
        exc_zero  = (divisor == '0);
        exc_ovf   = sgn && (dividend == MIN_VAL) && (divisor == '1);
        iter_last = (cnt == CW'(WIDTH - 1));
        // Sign of the old partial remainder picks subtract or add for this step.
        a_shift   = {a_reg[WIDTH-1:0], q_reg[WIDTH-1]};
        a_step    = a_reg[WIDTH] ? (a_shift + m_reg) : (a_shift - m_reg);
        a_fix     = a_reg[WIDTH] ? (a_reg + m_reg) : a_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ready    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) state_nx = (exc_zero || exc_ovf) ? FINISH : ITER;
            end
            ITER: begin
                busy = 1'b1;
                if (iter_last) state_nx = CORRECT;
            end
            CORRECT: begin
                busy     = 1'b1;
                state_nx = FINISH;
            end
            FINISH: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg       <= '0;
            m_reg       <= '0;
            q_reg       <= '0;
            cnt         <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg       <= '0;
                        q_reg       <= dvd_mag;
                        m_reg       <= {1'b0, dvs_mag};
                        cnt         <= '0;
                        sign_q      <= dvd_neg ^ dvs_neg;
                        sign_r      <= dvd_neg;
                        div_by_zero <= exc_zero;
                        overflow    <= exc_ovf;
                        // Exceptions skip iteration, so their results land now.
                        if (exc_zero) begin
                            quotient  <= '1;
                            remainder <= dividend;
                        end else if (exc_ovf) begin
                            quotient  <= dividend;
                            remainder <= '0;
                        end
                    end
                end
                ITER: begin
                    a_reg <= a_step;
                    q_reg <= {q_reg[WIDTH-2:0], ~a_step[WIDTH]};
                    cnt   <= cnt + CW'(1);
                end
                CORRECT: begin
                    quotient  <= sign_q ? -q_reg : q_reg;
                    remainder <= sign_r ? -a_fix[WIDTH-1:0] : a_fix[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nonrestoring_divider_seq.sv
// tb/tb_nonrestoring_divider_seq.sv - self-checking bench for nonrestoring_divider_seq at several widths
module tb_nonrestoring_divider_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_v [4];
    logic        sm_v    [4];
    logic [63:0] dvd_v   [4];
    logic [63:0] dvs_v   [4];
    logic        rdy_v   [4];
    logic        bsy_v   [4];
    logic        dn_v    [4];
    logic        dz_v    [4];
    logic        ov_v    [4];
    logic [15:0] q0, r0, q1, r1;
    logic [7:0]  q2, r2;
    logic [31:0] q3, r3;
    logic [63:0] q_v [4];
    logic [63:0] r_v [4];

    int wid  [4];
    bit sgen [4];
    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    assign q_v[0] = {48'd0, q0};
    assign r_v[0] = {48'd0, r0};
    assign q_v[1] = {48'd0, q1};
    assign r_v[1] = {48'd0, r1};
    assign q_v[2] = {56'd0, q2};
    assign r_v[2] = {56'd0, r2};
    assign q_v[3] = {32'd0, q3};
    assign r_v[3] = {32'd0, r3};

    nonrestoring_divider_seq #(.WIDTH(16), .SIGNED_EN(1'b1)) u_d16 (
        .clk(clk), .rst(rst), .start(start_v[0]), .signed_mode(sm_v[0]),
        .dividend(dvd_v[0][15:0]), .divisor(dvs_v[0][15:0]),
        .ready(rdy_v[0]), .busy(bsy_v[0]), .done(dn_v[0]),
        .quotient(q0), .remainder(r0), .div_by_zero(dz_v[0]), .overflow(ov_v[0]));

    nonrestoring_divider_seq #(.WIDTH(16), .SIGNED_EN(1'b0)) u_d16u (
        .clk(clk), .rst(rst), .start(start_v[1]), .signed_mode(sm_v[1]),
        .dividend(dvd_v[1][15:0]), .divisor(dvs_v[1][15:0]),
        .ready(rdy_v[1]), .busy(bsy_v[1]), .done(dn_v[1]),
        .quotient(q1), .remainder(r1), .div_by_zero(dz_v[1]), .overflow(ov_v[1]));

    nonrestoring_divider_seq #(.WIDTH(8), .SIGNED_EN(1'b1)) u_d8 (
        .clk(clk), .rst(rst), .start(start_v[2]), .signed_mode(sm_v[2]),
        .dividend(dvd_v[2][7:0]), .divisor(dvs_v[2][7:0]),
        .ready(rdy_v[2]), .busy(bsy_v[2]), .done(dn_v[2]),
        .quotient(q2), .remainder(r2), .div_by_zero(dz_v[2]), .overflow(ov_v[2]));

    nonrestoring_divider_seq #(.WIDTH(32), .SIGNED_EN(1'b1)) u_d32 (
        .clk(clk), .rst(rst), .start(start_v[3]), .signed_mode(sm_v[3]),
        .dividend(dvd_v[3][31:0]), .divisor(dvs_v[3][31:0]),
        .ready(rdy_v[3]), .busy(bsy_v[3]), .done(dn_v[3]),
        .quotient(q3), .remainder(r3), .div_by_zero(dz_v[3]), .overflow(ov_v[3]));

    // Reference: plain integer division on the operands' numeric values.
    function automatic void model(input int w, input bit sg, input longint a_in, input longint b_in,
                                  output longint q, output longint r, output bit dz, output bit ov,
                                  output int lat);
        longint m, a, b, sa, sb;
        m   = (longint'(1) << w) - 1;
        a   = a_in & m;
        b   = b_in & m;
        dz  = 1'b0;
        ov  = 1'b0;
        lat = w + 2;
        if (b == 0) begin
            q = m; r = a; dz = 1'b1; lat = 1;
        end else if (sg) begin
            sa = ((a >> (w - 1)) != 0) ? a - (m + 1) : a;
            sb = ((b >> (w - 1)) != 0) ? b - (m + 1) : b;
            if (sa == -(longint'(1) << (w - 1)) && sb == -1) begin
                q = a; r = 0; ov = 1'b1; lat = 1;
            end else begin
                q = (sa / sb) & m;
                r = (sa % sb) & m;
            end
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    function automatic void pick(input int w, input bit corners, output longint a, output longint b);
        longint m;
        m = (longint'(1) << w) - 1;
        a = longint'({$urandom, $urandom}) & m;
        b = longint'({$urandom, $urandom}) & m;
        if (corners) begin
            case ($urandom_range(0, 7))
                0: b = 0;
                1: begin a = longint'(1) << (w - 1); b = m; end
                2: b = longint'($urandom_range(1, 3));
                3: a = longint'($urandom_range(0, 5));
                default: ;
            endcase
        end else if (b == 0) begin
            b = 1;
        end
    endfunction

    task automatic run_op(input int k, input bit sg, input longint a, input longint b,
                          output longint q, output longint r, output bit dz, output bit ov,
                          output int lat, output bit bz);
        int w = 0;
        while (rdy_v[k] !== 1'b1 && w < 100) begin @(negedge clk); w++; end
        start_v[k] = 1'b1;
        sm_v[k]    = sg;
        dvd_v[k]   = a;
        dvs_v[k]   = b;
        @(negedge clk);
        start_v[k] = 1'b0;
        dvd_v[k]   = {$urandom, $urandom};
        dvs_v[k]   = {$urandom, $urandom};
        lat = 1;
        bz  = 1'b1;
        while (dn_v[k] !== 1'b1 && lat < 200) begin
            if (bsy_v[k] !== 1'b1) bz = 1'b0;
            @(negedge clk);
            lat++;
        end
        q  = q_v[k];
        r  = r_v[k];
        dz = dz_v[k];
        ov = ov_v[k];
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            total++;
            if ({rdy_v[k], bsy_v[k], dn_v[k], dz_v[k], ov_v[k]} !== 5'b10000 || q_v[k] !== 64'd0 || r_v[k] !== 64'd0)
                $display("FAIL reset_state dut%0d: got rdy/bsy/dn/dz/ov=%b%b%b%b%b q=%0h r=%0h, want 10000 q=0 r=0",
                         k, rdy_v[k], bsy_v[k], dn_v[k], dz_v[k], ov_v[k], q_v[k], r_v[k]);
            else passed++;
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_unsigned();
        longint q, r; bit dz, ov, bz; int lat;
        run_op(0, 1'b0, 100, 7, q, r, dz, ov, lat, bz);
        total++;
        if ({q, r, dz, ov, lat, bz} !== {64'd14, 64'd2, 1'b0, 1'b0, 32'd18, 1'b1})
            $display("FAIL u_100_7: got q=%0h r=%0h dz=%0b ov=%0b lat=%0d busy=%0b, want q=e r=2 dz=0 ov=0 lat=18 busy=1", q, r, dz, ov, lat, bz);
        else passed++;
        total++;
        if ({dn_v[0], rdy_v[0]} !== 2'b01)
            $display("FAIL done_pulse: got done=%0b ready=%0b after done cycle, want done=0 ready=1", dn_v[0], rdy_v[0]);
        else passed++;
        run_op(0, 1'b0, 64'hFFFF, 1, q, r, dz, ov, lat, bz);
        total++;
        if ({q, r, dz, ov, lat} !== {64'hFFFF, 64'd0, 1'b0, 1'b0, 32'd18})
            $display("FAIL u_ffff_1: got q=%0h r=%0h dz=%0b ov=%0b lat=%0d, want q=ffff r=0 flags 0 lat=18", q, r, dz, ov, lat);
        else passed++;
        run_op(0, 1'b0, 5, 9, q, r, dz, ov, lat, bz);
        total++;
        if ({q, r, dz, ov} !== {64'd0, 64'd5, 1'b0, 1'b0})
            $display("FAIL u_5_9: got q=%0h r=%0h dz=%0b ov=%0b, want q=0 r=5 flags 0", q, r, dz, ov);
        else passed++;
    endtask

    task automatic test_signed();
        longint q, r; bit dz, ov, bz; int lat;
        run_op(0, 1'b1, 64'hFFF9, 2, q, r, dz, ov, lat, bz);
        total++;
        if ({q, r, dz, ov} !== {64'hFFFD, 64'hFFFF, 1'b0, 1'b0})
            $display("FAIL s_m7_2: got q=%0h r=%0h dz=%0b ov=%0b, want q=fffd r=ffff flags 0", q, r, dz, ov);
        else passed++;
        run_op(0, 1'b1, 7, 64'hFFFE, q, r, dz, ov, lat, bz);
        total++;
        if ({q, r, dz, ov} !== {64'hFFFD, 64'd1, 1'b0, 1'b0})
            $display("FAIL s_7_m2: got q=%0h r=%0h dz=%0b ov=%0b, want q=fffd r=1 flags 0", q, r, dz, ov);
        else passed++;
        run_op(1, 1'b1, 64'hFFF9, 2, q, r, dz, ov, lat, bz);
        total++;
        if ({q, r, dz, ov} !== {64'h7FFC, 64'd1, 1'b0, 1'b0})
            $display("FAIL signed_disabled: got q=%0h r=%0h dz=%0b ov=%0b, want q=7ffc r=1 flags 0", q, r, dz, ov);
        else passed++;
    endtask

    task automatic test_exceptions();
        longint q, r; bit dz, ov, bz; int lat;
        run_op(0, 1'b0, 1234, 0, q, r, dz, ov, lat, bz);
        total++;
        if ({q, r, dz, ov, lat} !== {64'hFFFF, 64'd1234, 1'b1, 1'b0, 32'd1})
            $display("FAIL div_zero: got q=%0h r=%0d dz=%0b ov=%0b lat=%0d, want q=ffff r=1234 dz=1 ov=0 lat=1", q, r, dz, ov, lat);
        else passed++;
        run_op(0, 1'b0, 64'h8000, 64'hFFFF, q, r, dz, ov, lat, bz);
        total++;
        if ({q, r, dz, ov, lat} !== {64'd0, 64'h8000, 1'b0, 1'b0, 32'd18})
            $display("FAIL u_min_ones: got q=%0h r=%0h dz=%0b ov=%0b lat=%0d, want q=0 r=8000 flags 0 lat=18", q, r, dz, ov, lat);
        else passed++;
        run_op(0, 1'b1, 64'h8000, 64'hFFFF, q, r, dz, ov, lat, bz);
        total++;
        if ({q, r, dz, ov, lat} !== {64'h8000, 64'd0, 1'b0, 1'b1, 32'd1})
            $display("FAIL s_overflow: got q=%0h r=%0h dz=%0b ov=%0b lat=%0d, want q=8000 r=0 dz=0 ov=1 lat=1", q, r, dz, ov, lat);
        else passed++;
    endtask

    task automatic test_reset_midop();
        longint q, r; bit dz, ov, bz, seen; int lat;
        start_v[0] = 1'b1; sm_v[0] = 1'b0; dvd_v[0] = 100; dvs_v[0] = 7;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({rdy_v[0], bsy_v[0], dn_v[0], dz_v[0], ov_v[0]} !== 5'b10000 || q_v[0] !== 64'd0 || r_v[0] !== 64'd0)
            $display("FAIL midop_reset: got rdy/bsy/dn/dz/ov=%b%b%b%b%b q=%0h r=%0h, want 10000 q=0 r=0",
                     rdy_v[0], bsy_v[0], dn_v[0], dz_v[0], ov_v[0], q_v[0], r_v[0]);
        else passed++;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (dn_v[0] === 1'b1) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) $display("FAIL abandoned_done: got done pulse=%0b, want 0", seen);
        else passed++;
        run_op(0, 1'b0, 50, 5, q, r, dz, ov, lat, bz);
        total++;
        if ({q, r, dz, ov, lat} !== {64'd10, 64'd0, 1'b0, 1'b0, 32'd18})
            $display("FAIL after_reset_50_5: got q=%0h r=%0h dz=%0b ov=%0b lat=%0d, want q=a r=0 flags 0 lat=18", q, r, dz, ov, lat);
        else passed++;
    endtask

    task automatic test_back_to_back(input int k, input int n, input bit corners);
        longint eq[$], er[$];
        bit     edz[$], eov[$];
        int     elat[$];
        longint a, b, q, r;
        bit     sg, dz, ov;
        int     lat, n_acc, n_done, cyc, last_done;
        n_acc = 0; n_done = 0; cyc = 0; last_done = -1;
        while (n_done < n && cyc < n * (wid[k] + 3) + 50) begin
            @(negedge clk);
            cyc++;
            if (dn_v[k] === 1'b1) begin
                total++;
                if (eq.size() == 0) begin
                    $display("FAIL b2b_spurious dut%0d: got done with nothing outstanding, want no done", k);
                end else begin
                    if ({q_v[k], r_v[k], dz_v[k], ov_v[k]} !== {eq[0], er[0], edz[0], eov[0]})
                        $display("FAIL b2b_result dut%0d op%0d: got q=%0h r=%0h dz=%0b ov=%0b, want q=%0h r=%0h dz=%0b ov=%0b",
                                 k, n_done, q_v[k], r_v[k], dz_v[k], ov_v[k], eq[0], er[0], edz[0], eov[0]);
                    else passed++;
                    if (last_done >= 0) begin
                        total++;
                        if (cyc - last_done !== elat[0] + 1)
                            $display("FAIL b2b_spacing dut%0d op%0d: got %0d cycles, want %0d", k, n_done, cyc - last_done, elat[0] + 1);
                        else passed++;
                    end
                    void'(eq.pop_front()); void'(er.pop_front());
                    void'(edz.pop_front()); void'(eov.pop_front()); void'(elat.pop_front());
                end
                last_done = cyc;
                n_done++;
            end
            if (rdy_v[k] === 1'b1) begin
                if (n_acc < n) begin
                    pick(wid[k], corners, a, b);
                    sg = 1'($urandom_range(0, 1));
                    model(wid[k], sg & sgen[k], a, b, q, r, dz, ov, lat);
                    eq.push_back(q); er.push_back(r); edz.push_back(dz); eov.push_back(ov); elat.push_back(lat);
                    start_v[k] = 1'b1; sm_v[k] = sg; dvd_v[k] = a; dvs_v[k] = b;
                    n_acc++;
                end else begin
                    start_v[k] = 1'b0;
                end
            end else begin
                sm_v[k]  = 1'($urandom_range(0, 1));
                dvd_v[k] = {$urandom, $urandom};
                dvs_v[k] = {$urandom, $urandom};
            end
        end
        start_v[k] = 1'b0;
        total++;
        if (n_done !== n) $display("FAIL b2b_count dut%0d: got %0d done pulses, want %0d", k, n_done, n);
        else passed++;
        @(negedge clk);
    endtask

    initial begin
        wid  = '{16, 16, 8, 32};
        sgen = '{1'b1, 1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 4; k++) begin
            start_v[k] = 1'b0; sm_v[k] = 1'b0; dvd_v[k] = '0; dvs_v[k] = '0;
        end
        test_reset();
        test_unsigned();
        test_signed();
        test_exceptions();
        test_reset_midop();
        test_back_to_back(0, 3, 1'b0);
        test_back_to_back(0, 20, 1'b1);
        test_back_to_back(1, 10, 1'b1);
        test_back_to_back(2, 40, 1'b1);
        test_back_to_back(3, 15, 1'b1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
